// File: rtl/timer_counter_if.sv
// Bridge-side port bundle for one timer instance: address/data/strobe in, read data and IRQ out.
interface timer_counter_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable
// expiry interrupt; decodes only Addr[3:2], the bridge handles window decode.
module timer_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [SEL_W-1:0] SEL_CTRL   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_PRESET = 2'd1;
  localparam logic [SEL_W-1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0]       MODE_AUTO  = 2'd1;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             irq_flag_q;

  logic [SEL_W-1:0] sel_c;
  logic             wr_ctrl_c, wr_preset_c;
  logic             load_c, dec_c, expire_c, reload_c, auto_clr_c;

  // Only Addr[3:2] and the low data bits matter; the rest are deliberately ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.Addr, bus.Din};

  assign sel_c       = bus.Addr[3:2];
  assign wr_ctrl_c   = bus.WE && (sel_c == SEL_CTRL);
  assign wr_preset_c = bus.WE && (sel_c == SEL_PRESET);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    dec_c      = 1'b0;
    expire_c   = 1'b0;
    reload_c   = 1'b0;
    auto_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          dec_c = 1'b1;
        end else begin
          expire_c = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (ctrl_q.mode == MODE_AUTO) reload_c   = 1'b1;
        else                          auto_clr_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CTRL: a CPU write overrides the one-shot EN auto-clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else if (wr_ctrl_c) begin
      ctrl_q <= ctrl_t'(bus.Din[CTRL_W-1:0]);
    end else if (auto_clr_c) begin
      ctrl_q.en <= 1'b0;
    end
  end

  // PRESET is only sampled by LOAD, so writes mid-count do not disturb COUNT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           preset_q <= '0;
    else if (wr_preset_c) preset_q <= bus.Din[CNT_W-1:0];
  end

  // COUNT saturates at zero; PRESET=0 still spends one CNT cycle before expiry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        count_q <= '0;
    else if (load_c)   count_q <= preset_q;
    else if (dec_c)    count_q <= count_q - CNT_W'(1);
    else if (expire_c) count_q <= '0;
  end

  // Expiry set has priority over clear-by-write and the auto-reload clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    irq_flag_q <= 1'b0;
    else if (expire_c)                             irq_flag_q <= 1'b1;
    else if (reload_c || wr_ctrl_c || wr_preset_c) irq_flag_q <= 1'b0;
  end

  // Zero-wait-state read mux of pre-edge register values
  always_comb begin
    bus.Dout = '0;
    case (sel_c)
      SEL_CTRL:   bus.Dout = DATA_W'(ctrl_q);
      SEL_PRESET: bus.Dout = DATA_W'(preset_q);
      SEL_COUNT:  bus.Dout = DATA_W'(count_q);
      default:    bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = ctrl_q.im & irq_flag_q;

endmodule
